fifo_param: RTL and testbench
=============================

# fifo_param

Parametrised synchronous FIFO: storage array, internal read/write pointers, occupancy count, threshold flags and sticky error flags in one block. It replaces the bare memory plus externally driven pointers in the transmit-layer datapath, so upstream and downstream logic only drive `wr_enable`/`rd_enable`. One instance is used per lane buffer. Width, depth and both thresholds are set per instance.

## Interface
- `data_width`, 6, word width in bits
- `address_width`, 3, pointer width; depth = 2^`address_width`
- `almost_full_th`, 6, `almost_full` asserts when count >= this value (1..depth)
- `almost_empty_th`, 2, `almost_empty` asserts when count <= this value (0..depth-1)

- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `wr_enable`  in  1  write request
- `rd_enable`  in  1  read request
- `FIFO_data_in`  in  `data_width`  write data
- `FIFO_data_out`  out  `data_width`  registered read data
- `valid_out`  out  1  `FIFO_data_out` updated this cycle
- `fifo_count`  out  `address_width`+1  words stored (0..depth)
- `fifo_full`, `fifo_empty`  out  1 each  count == depth / count == 0
- `almost_full`, `almost_empty`  out  1 each  threshold flags
- `overflow`, `underflow`  out  1 each  sticky error flags

## Operation
- Reset values: `wr_ptr`=0, `rd_ptr`=0, count=0, `FIFO_data_out`=0, `valid_out`=0, `fifo_empty`=1, `fifo_full`=0, `almost_empty`=1, `almost_full`=0, `overflow`=0, `underflow`=0. Memory contents are not cleared.
- Write accepted when `wr_enable` && (!`fifo_full` || read accepted same cycle):
  - mem[`wr_ptr`] <= `FIFO_data_in`
  - `wr_ptr` += 1
- Read accepted when `rd_enable` && !`fifo_empty`:
  - `FIFO_data_out` <= mem[`rd_ptr`], `valid_out` <= 1, `rd_ptr` += 1
  - Otherwise `FIFO_data_out` holds its value and `valid_out` <= 0.
- Count update: +1 write only; −1 read only; unchanged for both or neither.
- Pointers are `address_width` bits and wrap modulo depth. Full and empty are distinguished by count, never by pointer compare.
- Flags are decoded combinationally from the count register, so they change in the same cycle as `fifo_count`.
- Simultaneous read and write:
  - Full: both accepted, count stays at depth, no overflow.
  - Empty: write accepted, read rejected (no fall-through), `underflow` set, count becomes 1.
- `overflow` sets on `wr_enable` while full with no accepted read. The word is dropped; memory and pointers are unchanged.
- `underflow` sets on `rd_enable` while empty. Outputs hold and `valid_out`=0.
- `overflow` and `underflow` stay set until reset.
- Reset has priority over any concurrent read or write. Asserting it mid-operation discards all contents logically (count=0) on the next edge.

## Timing
- Write to readable: data written at edge N is visible to a read issued in cycle N+1. Its data appears on `FIFO_data_out` after edge N+1.
- Read latency: 1 clock from the accepting edge to `FIFO_data_out`/`valid_out`.
- Throughput: one read and one write per clock sustained.
- Flag latency: zero cycles relative to `fifo_count`. Flags reflect the state after the last edge.

## Test plan
- Reset then idle 3 cycles -> all outputs at reset values; `fifo_empty`=1, `almost_empty`=1, `fifo_count`=0.
- Fill: write 0x15, 0x3F, 0x0B, 0x3C, 0x21, 0x15, 0x3F, 0x00 on consecutive cycles ->
  - `almost_empty` drops when count reaches 3
  - `almost_full` rises when count reaches 6
  - `fifo_full`=1 and count=8 after the 8th write
- While full, write 0x39 with no read -> `overflow`=1, count=8. Then drain 8 reads -> `FIFO_data_out` = 0x15, 0x3F, 0x0B, 0x3C, 0x21, 0x15, 0x3F, 0x00 with `valid_out`=1 on each; `fifo_empty`=1 at end.
- On empty, assert `rd_enable` with `wr_enable`=1 and data 0x2A ->
  - `underflow`=1, `valid_out`=0, `FIFO_data_out` holds 0x00, count=1
  - next read returns 0x2A
- At full, assert read and write (data 0x07) together -> count stays 8, no `overflow`, oldest word output. 0x07 is read out last after a full drain.
- Wrap and reset: write 5 words, read 5, then write 6 words 0x01..0x06 -> pointers cross index 7→0 and reads return 0x01..0x06 in order. Next, assert `reset` with `wr_enable`/`rd_enable` high -> count=0, `valid_out`=0, `overflow`/`underflow` cleared.

Source files
------------

// File: rtl/fifo_param_if.sv
// fifo_param_if: handshake and status bundle for one FIFO lane buffer.
//   master modport (producer/consumer side): drives wr_enable, rd_enable and
//     FIFO_data_in; observes read data, count and all flags.
//   slave modport (FIFO side): the mirror image.
// Parameters must match those of the fifo_param instance the bundle connects to.
interface fifo_param_if #(
  parameter int data_width    = 6,
  parameter int address_width = 3
) ();
  logic                   wr_enable;
  logic                   rd_enable;
  logic [data_width-1:0]  FIFO_data_in;
  logic [data_width-1:0]  FIFO_data_out;
  logic                   valid_out;
  logic [address_width:0] fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   almost_full;
  logic                   almost_empty;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output wr_enable, rd_enable, FIFO_data_in,
    input  FIFO_data_out, valid_out, fifo_count, fifo_full, fifo_empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr_enable, rd_enable, FIFO_data_in,
    output FIFO_data_out, valid_out, fifo_count, fifo_full, fifo_empty,
           almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with internal pointers, occupancy
// count, threshold flags and sticky overflow/underflow flags.
// Ports:
//   clk   - single clock, all state updates on the rising edge
//   reset - synchronous, active-high; wins over any concurrent read/write
//   bus   - fifo_param_if slave: wr_enable/rd_enable/FIFO_data_in in;
//           FIFO_data_out (registered, 1-cycle read latency), valid_out,
//           fifo_count, fifo_full/fifo_empty, almost_full/almost_empty,
//           overflow/underflow out.
// Full/empty are decoded from the count register, never from pointer compare,
// so the pointers may wrap freely modulo depth.
module fifo_param #(
  parameter int data_width      = 6,
  parameter int address_width   = 3,
  parameter int almost_full_th  = 6,
  parameter int almost_empty_th = 2
) (
  input logic        clk,
  input logic        reset,
  fifo_param_if.slave bus
);
  localparam int depth = 1 << address_width;
  localparam logic [address_width:0]   depth_count = (address_width + 1)'(depth);
  localparam logic [address_width:0]   af_count    = (address_width + 1)'(almost_full_th);
  localparam logic [address_width:0]   ae_count    = (address_width + 1)'(almost_empty_th);
  localparam logic [address_width:0]   count_one   = (address_width + 1)'(1);
  localparam logic [address_width-1:0] ptr_one     = address_width'(1);

  logic [data_width-1:0]    mem [depth];
  logic [address_width-1:0] wr_ptr_reg;
  logic [address_width-1:0] rd_ptr_reg;
  logic [address_width:0]   count_reg;
  logic [data_width-1:0]    data_out_reg;
  logic                     valid_reg;
  logic                     overflow_reg;
  logic                     underflow_reg;

  logic full;
  logic empty;
  logic rd_accept;
  logic wr_accept;

  assign full  = (count_reg == depth_count);
  assign empty = (count_reg == '0);

  // A read on empty never falls through to a same-cycle write; a write on
  // full is only taken when a read frees a slot on the same edge.
  assign rd_accept = bus.rd_enable && !empty;
  assign wr_accept = bus.wr_enable && (!full || rd_accept);

  // Storage: no reset so it maps onto block RAM; writes are suppressed while
  // reset is asserted so reset keeps strict priority.
  always_ff @(posedge clk) begin
    if (wr_accept && !reset) begin
      mem[wr_ptr_reg] <= bus.FIFO_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      data_out_reg  <= '0;
      valid_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + ptr_one;
      end

      if (rd_accept) begin
        data_out_reg <= mem[rd_ptr_reg];
        rd_ptr_reg   <= rd_ptr_reg + ptr_one;
        valid_reg    <= 1'b1;
      end else begin
        valid_reg    <= 1'b0;
      end

      case ({wr_accept, rd_accept})
        2'b10:   count_reg <= count_reg + count_one;
        2'b01:   count_reg <= count_reg - count_one;
        default: count_reg <= count_reg;
      endcase

      // Sticky until reset.
      if (bus.wr_enable && !wr_accept) begin
        overflow_reg <= 1'b1;
      end
      if (bus.rd_enable && empty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign bus.FIFO_data_out = data_out_reg;
  assign bus.valid_out     = valid_reg;
  assign bus.fifo_count    = count_reg;
  assign bus.fifo_full     = full;
  assign bus.fifo_empty    = empty;
  assign bus.almost_full   = (count_reg >= af_count);
  assign bus.almost_empty  = (count_reg <= ae_count);
  assign bus.overflow      = overflow_reg;
  assign bus.underflow     = underflow_reg;
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed stimulus for fifo_param with a read-data scoreboard.
// The stimulus process pushes the hand-computed word expected for each read it
// issues; an independent monitor pops and compares whenever valid_out is seen.
// Status outputs are checked directly by the stimulus process after each edge.
module tb_fifo_param;
  logic clk;
  logic reset;

  fifo_param_if #(.data_width(6), .address_width(3)) bus ();

  fifo_param #(
    .data_width(6),
    .address_width(3),
    .almost_full_th(6),
    .almost_empty_th(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  logic [5:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid_out", int'(bus.valid_out), 0);
      end else begin
        automatic logic [5:0] e = exp_q.pop_front();
        $display("read  data=0x%02h expected=0x%02h", bus.FIFO_data_out, e);
        check("rd_data", int'(bus.FIFO_data_out), int'(e));
      end
    end
  end

  // One clock cycle with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic w, input logic r, input logic [5:0] d);
    bus.wr_enable    = w;
    bus.rd_enable    = r;
    bus.FIFO_data_in = d;
    @(posedge clk);
    #1;
    bus.wr_enable    = 1'b0;
    bus.rd_enable    = 1'b0;
    bus.FIFO_data_in = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 1'b0, 6'h00);
    cyc(1'b0, 1'b0, 6'h00);
    reset = 1'b0;
  endtask

  logic [5:0] fill_vec [8] = '{6'h15, 6'h3F, 6'h0B, 6'h3C, 6'h21, 6'h15, 6'h3F, 6'h00};

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    bus.wr_enable = 1'b0;
    bus.rd_enable = 1'b0;
    bus.FIFO_data_in = '0;

    // Reset then idle 3 cycles.
    do_reset();
    repeat (3) cyc(1'b0, 1'b0, 6'h00);
    $display("idle  after reset count=%0d", bus.fifo_count);
    check("rst_count", int'(bus.fifo_count), 0);
    check("rst_empty", int'(bus.fifo_empty), 1);
    check("rst_full", int'(bus.fifo_full), 0);
    check("rst_almost_empty", int'(bus.almost_empty), 1);
    check("rst_almost_full", int'(bus.almost_full), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    check("rst_underflow", int'(bus.underflow), 0);
    check("rst_valid_out", int'(bus.valid_out), 0);
    check("rst_data_out", int'(bus.FIFO_data_out), 0);

    // Fill to full; thresholds track count with zero latency.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, fill_vec[i]);
      $display("write data=0x%02h count=%0d", fill_vec[i], bus.fifo_count);
      check("fill_count", int'(bus.fifo_count), i + 1);
      check("fill_almost_empty", int'(bus.almost_empty), (i + 1 <= 2) ? 1 : 0);
      check("fill_almost_full", int'(bus.almost_full), (i + 1 >= 6) ? 1 : 0);
      check("fill_full", int'(bus.fifo_full), (i == 7) ? 1 : 0);
    end

    // Write while full with no read: dropped, overflow set.
    cyc(1'b1, 1'b0, 6'h39);
    $display("write data=0x39 on full");
    check("ovf_flag", int'(bus.overflow), 1);
    check("ovf_count", int'(bus.fifo_count), 8);

    // Drain: 0x39 must not appear.
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(fill_vec[i]);
      cyc(1'b0, 1'b1, 6'h00);
    end
    cyc(1'b0, 1'b0, 6'h00);
    check("drain_empty", int'(bus.fifo_empty), 1);
    check("drain_count", int'(bus.fifo_count), 0);

    // Read+write on empty: write taken, read rejected.
    cyc(1'b1, 1'b1, 6'h2A);
    $display("rd+wr data=0x2A on empty");
    check("uf_flag", int'(bus.underflow), 1);
    check("uf_valid_out", int'(bus.valid_out), 0);
    check("uf_data_hold", int'(bus.FIFO_data_out), 8'h00);
    check("uf_count", int'(bus.fifo_count), 1);
    exp_q.push_back(6'h2A);
    cyc(1'b0, 1'b1, 6'h00);
    cyc(1'b0, 1'b0, 6'h00);

    // Fresh reset so overflow starts clear for the full rd+wr case.
    do_reset();
    check("rst2_underflow", int'(bus.underflow), 0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 6'(8'h10 + i));
    exp_q.push_back(6'h10);
    cyc(1'b1, 1'b1, 6'h07);
    $display("rd+wr data=0x07 on full count=%0d", bus.fifo_count);
    check("full_rw_count", int'(bus.fifo_count), 8);
    check("full_rw_overflow", int'(bus.overflow), 0);
    check("full_rw_full", int'(bus.fifo_full), 1);
    for (int i = 1; i < 8; i++) exp_q.push_back(6'(8'h10 + i));
    exp_q.push_back(6'h07);
    repeat (8) cyc(1'b0, 1'b1, 6'h00);
    cyc(1'b0, 1'b0, 6'h00);
    check("full_rw_empty", int'(bus.fifo_empty), 1);

    // Wrap: pointers sit at 1; 5 in/5 out, then 6 more cross index 7->0.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 6'(8'h20 + i));
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(6'(8'h20 + i));
      cyc(1'b0, 1'b1, 6'h00);
    end
    for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b0, 6'(i));
    check("wrap_count", int'(bus.fifo_count), 6);
    check("wrap_almost_full", int'(bus.almost_full), 1);
    for (int i = 1; i <= 6; i++) begin
      exp_q.push_back(6'(i));
      cyc(1'b0, 1'b1, 6'h00);
    end
    cyc(1'b0, 1'b0, 6'h00);

    // Set both sticky flags, then reset with read and write requested.
    cyc(1'b0, 1'b1, 6'h00);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 6'(8'h30 + i));
    check("pre_rst_overflow", int'(bus.overflow), 1);
    check("pre_rst_underflow", int'(bus.underflow), 1);
    reset = 1'b1;
    cyc(1'b1, 1'b1, 6'h3E);
    reset = 1'b0;
    $display("reset with wr/rd high count=%0d", bus.fifo_count);
    check("mid_rst_count", int'(bus.fifo_count), 0);
    check("mid_rst_valid_out", int'(bus.valid_out), 0);
    check("mid_rst_data_out", int'(bus.FIFO_data_out), 0);
    check("mid_rst_overflow", int'(bus.overflow), 0);
    check("mid_rst_underflow", int'(bus.underflow), 0);
    check("mid_rst_empty", int'(bus.fifo_empty), 1);

    repeat (3) cyc(1'b0, 1'b0, 6'h00);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
